// File: rtl/cu_pkg.sv
// cu_pkg: fixed OpCode/Funct encodings, ALU operation codes and the decoded control bundle.
package cu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8
  } aluOp_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef struct packed {
    logic   regDst;
    logic   aluSrc1;
    logic   aluSrc2;
    aluOp_t aluOp;
    logic   memRdEn;
    logic   memWrEn;
    logic   memtoReg;
    logic   regWrEn;
    logic   branchEq;
    logic   branchNeq;
    logic   jump;
    logic   jumpReg;
    logic   invalidInst;
  } ctrl_t;
endpackage

// File: rtl/mips_control_unit_if.sv
// mips_control_unit_if: instruction fields in, datapath control strobes out.
interface mips_control_unit_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       RegDst;
  logic       ALUSrc1;
  logic       ALUSrc2;
  logic [3:0] ALUOp;
  logic       MemRdEn;
  logic       MemWrEn;
  logic       MemtoReg;
  logic       RegWrEn;
  logic       BranchEq;
  logic       BranchNeq;
  logic       Jump;
  logic       JumpReg;
  logic       InvalidInst;
  logic       InvalidSticky;
  modport master (
    output OpCode, Funct,
    input  RegDst, ALUSrc1, ALUSrc2, ALUOp, MemRdEn, MemWrEn, MemtoReg, RegWrEn,
           BranchEq, BranchNeq, Jump, JumpReg, InvalidInst, InvalidSticky
  );
  modport slave (
    input  OpCode, Funct,
    output RegDst, ALUSrc1, ALUSrc2, ALUOp, MemRdEn, MemWrEn, MemtoReg, RegWrEn,
           BranchEq, BranchNeq, Jump, JumpReg, InvalidInst, InvalidSticky
  );
endinterface

// File: rtl/cu_funct_decoder.sv
// cu_funct_decoder: R-type Funct to ALU op / shamt select / jr; CU_EXT_RTYPE_EN adds xor, nor, srl.
module cu_funct_decoder
  import cu_pkg::*;
(
  input  logic [5:0] funct,
  output aluOp_t     aluOp,
  output logic       rtypeValid,
  output logic       jumpReg,
  output logic       aluSrc1
);
  always_comb begin
    aluOp = ALU_ADD;
    rtypeValid = 1'b1;
    jumpReg = 1'b0;
    aluSrc1 = 1'b0;
    case (funct)
      FN_ADD: aluOp = ALU_ADD;
      FN_SUB: aluOp = ALU_SUB;
      FN_AND: aluOp = ALU_AND;
      FN_OR:  aluOp = ALU_OR;
      FN_SLT: aluOp = ALU_SLT;
      FN_SLL: begin aluOp = ALU_SLL; aluSrc1 = 1'b1; end
      FN_JR:  jumpReg = 1'b1;
`ifdef CU_EXT_RTYPE_EN
      FN_XOR: aluOp = ALU_XOR;
      FN_NOR: aluOp = ALU_NOR;
      FN_SRL: begin aluOp = ALU_SRL; aluSrc1 = 1'b1; end
`endif
      default: rtypeValid = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_control_unit.sv
// mips_control_unit: single-cycle MIPS main decoder, reset-gated outputs and sticky illegal flag.
// Optional CU_EXT_RTYPE_EN enables the xor/nor/srl R-type functs in cu_funct_decoder.
module mips_control_unit
  import cu_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  mips_control_unit_if.slave cu
);
  aluOp_t fnAluOp;
  logic   fnValid, fnJumpReg, fnAluSrc1, invalidSticky;
  ctrl_t  dec, ctl;
  cu_funct_decoder uFunct (
    .funct(cu.Funct), .aluOp(fnAluOp), .rtypeValid(fnValid), .jumpReg(fnJumpReg), .aluSrc1(fnAluSrc1)
  );
  always_comb begin
    dec = '0;
    case (cu.OpCode)
      OP_RTYPE: begin
        dec.invalidInst = !fnValid;
        dec.regDst = fnValid && !fnJumpReg;
        dec.regWrEn = fnValid && !fnJumpReg;
        dec.aluOp = fnAluOp;
        dec.aluSrc1 = fnAluSrc1;
        dec.jumpReg = fnJumpReg;
      end
      OP_ADDI: {dec.aluSrc2, dec.regWrEn} = 2'b11;
      OP_ANDI: begin {dec.aluSrc2, dec.regWrEn} = 2'b11; dec.aluOp = ALU_AND; end
      OP_ORI:  begin {dec.aluSrc2, dec.regWrEn} = 2'b11; dec.aluOp = ALU_OR; end
      OP_XORI: begin {dec.aluSrc2, dec.regWrEn} = 2'b11; dec.aluOp = ALU_XOR; end
      OP_SLTI: begin {dec.aluSrc2, dec.regWrEn} = 2'b11; dec.aluOp = ALU_SLT; end
      OP_LW:   {dec.aluSrc2, dec.memRdEn, dec.memtoReg, dec.regWrEn} = 4'b1111;
      OP_SW:   {dec.aluSrc2, dec.memWrEn} = 2'b11;
      OP_BEQ:  begin dec.branchEq = 1'b1; dec.aluOp = ALU_SUB; end
      OP_BNE:  begin dec.branchNeq = 1'b1; dec.aluOp = ALU_SUB; end
      OP_J:    dec.jump = 1'b1;
      OP_JAL:  {dec.jump, dec.regWrEn} = 2'b11;
      default: dec.invalidInst = 1'b1;
    endcase
  end
  assign ctl = rst_n ? dec : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) invalidSticky <= 1'b0;
    else if (ctl.invalidInst) invalidSticky <= 1'b1;
  end
  assign cu.RegDst = ctl.regDst;
  assign cu.ALUSrc1 = ctl.aluSrc1;
  assign cu.ALUSrc2 = ctl.aluSrc2;
  assign cu.ALUOp = ctl.aluOp;
  assign cu.MemRdEn = ctl.memRdEn;
  assign cu.MemWrEn = ctl.memWrEn;
  assign cu.MemtoReg = ctl.memtoReg;
  assign cu.RegWrEn = ctl.regWrEn;
  assign cu.BranchEq = ctl.branchEq;
  assign cu.BranchNeq = ctl.branchNeq;
  assign cu.Jump = ctl.jump;
  assign cu.JumpReg = ctl.jumpReg;
  assign cu.InvalidInst = ctl.invalidInst;
  assign cu.InvalidSticky = invalidSticky;
endmodule

// File: tb/tb_mips_control_unit.sv
// tb_mips_control_unit: table-driven reference with a scoreboard queue; directed then random vectors.
module tb_mips_control_unit;
  typedef struct {
    logic [15:0] ctl;
    logic        sticky;
    logic [5:0]  op;
    logic [5:0]  fn;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  logic [15:0] rtab[logic [5:0]];
  logic [15:0] itab[logic [5:0]];
  localparam logic [15:0] INV = 16'h0001;
  mips_control_unit_if cu ();
  mips_control_unit dut (.clk(clk), .rst_n(rst_n), .cu(cu));
  always #5 clk = ~clk;
  // ctl layout: RegDst ALUSrc1 ALUSrc2 ALUOp[3:0] MemRd MemWr MemtoReg RegWr Beq Bne Jump JumpReg Invalid
  function automatic logic [15:0] pk(logic rd, logic s1, logic s2, logic [3:0] op, logic mr, logic mw,
                                     logic m2r, logic rw, logic be, logic bn, logic j, logic jr);
    return {rd, s1, s2, op, mr, mw, m2r, rw, be, bn, j, jr, 1'b0};
  endfunction
  function automatic logic [15:0] model(logic r, logic [5:0] op, logic [5:0] fn);
    if (!r) return 16'h0;
    if (op == 6'h00) return rtab.exists(fn) ? rtab[fn] : INV;
    return itab.exists(op) ? itab[op] : INV;
  endfunction
  initial begin
    rtab[6'h20] = pk(1, 0, 0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h22] = pk(1, 0, 0, 4'd1, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h24] = pk(1, 0, 0, 4'd2, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h25] = pk(1, 0, 0, 4'd3, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h2A] = pk(1, 0, 0, 4'd6, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h00] = pk(1, 1, 0, 4'd7, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h08] = pk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef CU_EXT_RTYPE_EN
    rtab[6'h26] = pk(1, 0, 0, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h27] = pk(1, 0, 0, 4'd5, 0, 0, 0, 1, 0, 0, 0, 0);
    rtab[6'h02] = pk(1, 1, 0, 4'd8, 0, 0, 0, 1, 0, 0, 0, 0);
`endif
    itab[6'h08] = pk(0, 0, 1, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
    itab[6'h0C] = pk(0, 0, 1, 4'd2, 0, 0, 0, 1, 0, 0, 0, 0);
    itab[6'h0D] = pk(0, 0, 1, 4'd3, 0, 0, 0, 1, 0, 0, 0, 0);
    itab[6'h0E] = pk(0, 0, 1, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0);
    itab[6'h0A] = pk(0, 0, 1, 4'd6, 0, 0, 0, 1, 0, 0, 0, 0);
    itab[6'h23] = pk(0, 0, 1, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0);
    itab[6'h2B] = pk(0, 0, 1, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0);
    itab[6'h04] = pk(0, 0, 0, 4'd1, 0, 0, 0, 0, 1, 0, 0, 0);
    itab[6'h05] = pk(0, 0, 0, 4'd1, 0, 0, 0, 0, 0, 1, 0, 0);
    itab[6'h02] = pk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    itab[6'h03] = pk(0, 0, 0, 4'd0, 0, 0, 0, 1, 0, 0, 1, 0);
  end
  // directed vectors {rst_n, OpCode, Funct}
  localparam int ND = 34;
  logic [12:0] dir[ND] = '{
    {1'b0, 6'h23, 6'h00}, {1'b0, 6'h23, 6'h00},
    {1'b1, 6'h00, 6'h20}, {1'b1, 6'h00, 6'h22}, {1'b1, 6'h00, 6'h24}, {1'b1, 6'h00, 6'h25},
    {1'b1, 6'h00, 6'h2A}, {1'b1, 6'h00, 6'h00}, {1'b1, 6'h00, 6'h08},
    {1'b1, 6'h08, 6'h15}, {1'b1, 6'h0C, 6'h3F}, {1'b1, 6'h0D, 6'h00}, {1'b1, 6'h0E, 6'h2A},
    {1'b1, 6'h0A, 6'h08}, {1'b1, 6'h23, 6'h00}, {1'b1, 6'h2B, 6'h20}, {1'b1, 6'h04, 6'h00},
    {1'b1, 6'h05, 6'h00}, {1'b1, 6'h02, 6'h00}, {1'b1, 6'h03, 6'h00},
    {1'b1, 6'h00, 6'h26}, {1'b1, 6'h00, 6'h27}, {1'b1, 6'h00, 6'h02},
    {1'b0, 6'h3F, 6'h00}, {1'b1, 6'h20, 6'h20},
    {1'b1, 6'h00, 6'h3F}, {1'b0, 6'h00, 6'h20},
    {1'b1, 6'h3F, 6'h00}, {1'b1, 6'h23, 6'h00}, {1'b1, 6'h00, 6'h20}, {1'b1, 6'h04, 6'h00},
    {1'b0, 6'h3F, 6'h00}, {1'b1, 6'h23, 6'h00}, {1'b1, 6'h08, 6'h00}
  };
  logic prevRst = 1'b0;
  logic prevInv = 1'b0;
  logic stickyM = 1'b0;
  task automatic apply(logic r, logic [5:0] op, logic [5:0] fn);
    exp_t e;
    @(posedge clk);
    #1;
    stickyM = !prevRst ? 1'b0 : (prevInv ? 1'b1 : stickyM);
    rst_n = r;
    cu.OpCode = op;
    cu.Funct = fn;
    e.ctl = model(r, op, fn);
    e.sticky = stickyM;
    e.op = op;
    e.fn = fn;
    q.push_back(e);
    prevRst = r;
    prevInv = e.ctl[0];
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] got;
      e = q.pop_front();
      got = {cu.RegDst, cu.ALUSrc1, cu.ALUSrc2, cu.ALUOp, cu.MemRdEn, cu.MemWrEn, cu.MemtoReg,
             cu.RegWrEn, cu.BranchEq, cu.BranchNeq, cu.Jump, cu.JumpReg, cu.InvalidInst};
      tests++;
      if (got !== e.ctl) begin
        fails++;
        $display("FAIL ctl op=%h fn=%h got=%b exp=%b", e.op, e.fn, got, e.ctl);
      end
      tests++;
      if (cu.InvalidSticky !== e.sticky) begin
        fails++;
        $display("FAIL sticky op=%h fn=%h got=%b exp=%b", e.op, e.fn, cu.InvalidSticky, e.sticky);
      end
    end
  end
  initial begin
    logic [12:0] v;
    logic [5:0] op;
    logic [5:0] known[12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    cu.OpCode = 6'h23;
    cu.Funct = 6'h00;
    for (int i = 0; i < ND; i++) begin
      v = dir[i];
      apply(v[12], v[11:6], v[5:0]);
    end
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) < 8) ? known[$urandom_range(0, 11)] : 6'($urandom);
      apply($urandom_range(0, 19) != 0, op, 6'($urandom));
    end
    @(posedge clk);
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
Main decoder for the single-cycle MIPS datapath. It maps the 6-bit OpCode and the 6-bit Funct field to every datapath control strobe and to a 4-bit ALU operation code. Decode is combinational so each instruction completes in one cycle. The clock and reset drive only the reset gating of the outputs and a sticky illegal-instruction flag.

Parameters:
none (all encodings are fixed constants in cu_pkg)

Ports:
clk  in  1  system clock; only clock in the block
rst_n  in  1  reset, synchronous, active-low
OpCode  in  6  instruction[31:26]
Funct  in  6  instruction[5:0]; ignored unless OpCode==0x00
RegDst  out  1  1=write rd, 0=write rt
ALUSrc1  out  1  1=ALU A input takes shamt (shifts), 0=rs
ALUSrc2  out  1  1=ALU B input takes extended immediate, 0=rt
ALUOp  out  4  ALU operation code
MemRdEn  out  1  data-memory read enable
MemWrEn  out  1  data-memory write enable
MemtoReg  out  1  1=write-back data comes from memory
RegWrEn  out  1  register-file write enable
BranchEq  out  1  beq
BranchNeq  out  1  bne
Jump  out  1  j or jal
JumpReg  out  1  jr
InvalidInst  out  1  current OpCode/Funct is unsupported
InvalidSticky  out  1  registered flag: an invalid instruction was decoded since the last reset

Behaviour:
- ALUOp encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOR=0101, SLT=0110, SLL=0111, SRL=1000.
- Defaults: every output is 0 and ALUOp=ADD unless a row below sets it.
- R-type (OpCode 0x00): RegDst=1, RegWrEn=1.
  - add 0x20 -> ADD.
  - sub 0x22 -> SUB.
  - and 0x24 -> AND.
  - or 0x25 -> OR.
  - slt 0x2A -> SLT.
  - sll 0x00 -> SLL, ALUSrc1=1.
  - jr 0x08 -> JumpReg=1, RegWrEn=0, RegDst=0.
- addi 0x08: ALUSrc2=1, RegWrEn=1, ADD.
- andi 0x0C: ALUSrc2=1, RegWrEn=1, AND.
- ori 0x0D: ALUSrc2=1, RegWrEn=1, OR.
- xori 0x0E: ALUSrc2=1, RegWrEn=1, XOR.
- slti 0x0A: ALUSrc2=1, RegWrEn=1, SLT.
- lw 0x23: ALUSrc2=1, MemRdEn=1, MemtoReg=1, RegWrEn=1, ADD.
- sw 0x2B: ALUSrc2=1, MemWrEn=1, ADD.
- beq 0x04: BranchEq=1, SUB.
- bne 0x05: BranchNeq=1, SUB.
- j 0x02: Jump=1.
- jal 0x03: Jump=1, RegWrEn=1. The datapath forces $31 and PC+4 whenever Jump&RegWrEn.
- Any other OpCode, or OpCode 0x00 with an unlisted Funct: InvalidInst=1 and every other output at its default (no writes, no control transfer).
- For OpCode!=0, outputs are independent of Funct, including X/Z values on Funct.
- Decode latency is 0 cycles: purely combinational from OpCode/Funct.
- Reset: while rst_n==0, all combinational outputs are forced to 0 and ALUOp=0000. This gating is combinational, so the outputs are safe during reset.
- InvalidSticky:
  - cleared to 0 on the clk rising edge when rst_n==0 (synchronous reset);
  - otherwise set on any rising edge where InvalidInst==1;
  - holds until the next reset;
  - reset wins when reset and an invalid instruction coincide.

Optional Feature:
CU_EXT_RTYPE_EN
- Defined: the following additional R-type Functs decode with RegDst=1, RegWrEn=1:
  - xor 0x26 -> XOR;
  - nor 0x27 -> NOR;
  - srl 0x02 -> SRL, ALUSrc1=1.
- Undefined: these three Functs decode as invalid (InvalidInst=1).

Decomposition:
- cu_pkg holds the OpCode constants, the Funct constants and the ALUOp enum/localparams. The datapath ALU also imports it.
- One sub-module, cu_funct_decoder, maps Funct to ALUOp, the R-type valid bit, JumpReg and ALUSrc1.
- The top level holds the opcode case, the reset gating and the sticky register.

Test Plan:
- rst_n=0 held two cycles with OpCode=0x23 -> all outputs 0, ALUOp=0000, InvalidSticky=0.
- OpCode=0x00 with Funct 0x20/0x22/0x24/0x25/0x2A/0x00 -> ALUOp 0000/0001/0010/0011/0110/0111, RegDst=1, RegWrEn=1; ALUSrc1=1 only for 0x00.
- Funct=0x08 -> JumpReg=1, RegWrEn=0. Funct=0x3F -> InvalidInst=1, RegWrEn=0.
- OpCodes 0x08/0x0C/0x0D/0x0E/0x0A with Funct=X -> ALUSrc2=1, RegWrEn=1, ALUOp 0000/0010/0011/0100/0110, no X on any output.
- lw 0x23 -> MemRdEn=1, MemtoReg=1, RegWrEn=1. sw 0x2B -> MemWrEn=1, RegWrEn=0. beq 0x04 -> BranchEq=1, SUB. bne 0x05 -> BranchNeq=1, SUB. j 0x02 -> Jump=1, RegWrEn=0. jal 0x03 -> Jump=1, RegWrEn=1.
- OpCode=0x3F -> InvalidInst=1 the same cycle and InvalidSticky=1 after the next edge. InvalidSticky stays 1 across later valid instructions and clears only after a rising edge with rst_n=0.
